uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer between NUM_REQ byte-stream requesters, e.g. the auth responder (READY/result bytes) and a diagnostic/event reporter.
- Grants one requester per frame, round-robin. A frame is a byte sequence terminated by req_last, and it is never interleaved with another requester's bytes.
- Drives the uart_tx i_Tx_DV/i_Tx_Byte inputs and sequences on o_Tx_Active/o_Tx_Done.
- A watchdog releases a stalled frame.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 1350000, cycles without byte progress before the frame is aborted (50 ms at 27 MHz).
- CNT_W, 32, width of the watchdog counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_byte  in  8*NUM_REQ  flat byte bus; requester i uses [i*8 +: 8]
- req_last  in  NUM_REQ  byte is the last of its frame
- req_ready  out  NUM_REQ  one-cycle pulse: byte i accepted
- tx_dv  out  1  to uart_tx i_Tx_DV
- tx_byte  out  8  to uart_tx i_Tx_Byte
- tx_active  in  1  from uart_tx o_Tx_Active
- tx_done  in  1  from uart_tx o_Tx_Done
- grant_id  out  3  index of the current or last granted requester
- busy  out  1  high while a frame owns the TX
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst=1):
  - state=ST_IDLE, tx_dv=0, tx_byte=0, req_ready=0, grant_id=0, busy=0, timeout_err=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority; watchdog=0.
- All outputs are registered. tx_dv and req_ready default to 0 every cycle.
- ST_IDLE:
  - If any req_valid is set, select the first set bit searching upward from pointer+1, with wrap.
  - Register grant_id, set busy=1, go to ST_ISSUE.
  - tx_done seen in ST_IDLE is ignored.
- ST_ISSUE:
  - When req_valid[grant_id]=1 and tx_active=0: pulse tx_dv=1 with tx_byte=req_byte[grant_id].
  - In the same cycle pulse req_ready[grant_id]=1, latch last_flag=req_last[grant_id], clear the watchdog, go to ST_WAIT_DONE.
  - Otherwise hold; a gap mid-frame keeps the grant.
- ST_WAIT_DONE:
  - On tx_done: if last_flag=1, set pointer=grant_id, busy=0, go to ST_IDLE; else clear the watchdog and go to ST_ISSUE.
- Latency:
  - req_valid high in ST_IDLE at edge k (TX idle) gives grant at k; tx_dv and req_ready are high during the cycle after edge k+1.
  - Back-to-back frame bytes are separated by one uart_tx frame time plus 2 cycles.
- Requester contract:
  - Hold req_byte/req_last stable while req_valid=1 until req_ready.
  - A new byte may be presented the cycle after req_ready.
- Non-granted req_ready stays 0. Requests arriving mid-frame wait; there is no preemption.
- Watchdog:
  - Increments in ST_ISSUE and ST_WAIT_DONE and saturates.
  - When it reaches TIMEOUT_CYC: pulse timeout_err, pointer=grant_id, busy=0, go to ST_IDLE.
  - An in-flight uart_tx byte is not aborted.
- Simultaneous tx_done and watchdog expiry: tx_done wins.
- Reset mid-frame: immediate return to reset values; the current frame is lost, and the requester must restart after reset.
- NUM_REQ=1 degenerates to a pass-through sequencer with the same timing.

Decomposition:
- Shared package fpga_pkg holds:
  - the protocol byte constants (MAGIC 8'hA5, READY 8'h52, ALLOW 8'h01, DENY 8'h00, ADDED 8'h02, DUP 8'hEE, ERR 8'hEF) and CRC8_POLY 8'h07;
  - the arbiter state typedef (ST_IDLE, ST_ISSUE, ST_WAIT_DONE);
  - ms-to-cycles helper constants.
- Sub-module rr_arbiter (parameter N) computes the round-robin selection: inputs request vector and pointer; outputs one-hot grant, index and any-request. uart_tx_arbiter instantiates it once.

Test Plan:
- Single frame: req0 sends A5,10,04 (last on 04) → three tx_dv pulses in order, each after tx_done; busy falls after the third tx_done; grant_id=0.
- Contention: req0 and req1 assert valid at the same edge after reset → req0 frame served fully first, then req1; a second simultaneous request → req1 first.
- No interleave: req1 raises valid during req0's 3-byte frame → no req_ready[1] until req0's last tx_done; then req1 is granted.
- Mid-frame gap: req0 drops valid for 100 cycles between bytes → grant held; req1 (valid) is not served; no timeout with TIMEOUT_CYC=1000.
- Watchdog: TIMEOUT_CYC=50, req0 sends a non-last byte then idles → timeout_err pulses exactly once about 50 cycles after the tx_done; state returns to idle; req1 is granted next.
- Reset: assert rst in ST_WAIT_DONE → all outputs 0 asynchronously; after release, a fresh req1 frame completes normally.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared constants and types for the FPGA auth/diagnostic UART path.
// Holds protocol bytes, CRC polynomial, arbiter states and ms-to-cycle helpers.
package fpga_pkg;

    // Protocol byte constants
    localparam logic [7:0] MAGIC     = 8'hA5;
    localparam logic [7:0] READY     = 8'h52;
    localparam logic [7:0] ALLOW     = 8'h01;
    localparam logic [7:0] DENY      = 8'h00;
    localparam logic [7:0] ADDED     = 8'h02;
    localparam logic [7:0] DUP       = 8'hEE;
    localparam logic [7:0] ERR       = 8'hEF;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // TX arbiter states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } arb_state_t;

    // Timing helpers for a 27 MHz system clock
    localparam int unsigned CLK_HZ     = 27_000_000;
    localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;

    function automatic int unsigned ms_to_cyc(input int unsigned ms);
        return ms * CYC_PER_MS;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request above ptr, with wrap.
// Ports: req (request vector), ptr (last served index) -> gnt (one-hot), idx, any.
module rr_arbiter
    import fpga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [2:0]   idx,
    output logic         any
);

    int   cand;
    logic found;

    // Offsets 1..N from ptr; offset N wraps back to ptr itself, so the
    // requester just served only wins when nobody else is asking.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand[2:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one uart_tx between NUM_REQ requesters.
// Ports: req_valid/req_byte/req_last/req_ready (requesters), tx_dv/tx_byte/tx_active/tx_done (uart_tx),
//        grant_id, busy, timeout_err (status). Async active-high rst.
module uart_tx_arbiter
    import fpga_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1350000,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_dv,
    output logic [7:0]           tx_byte,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t         state;
    logic [2:0]         ptr;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               last_flag;
    logic [CNT_W-1:0]   wdog;
    logic [CNT_W-1:0]   wdog_inc;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [2:0]         rr_idx;
    logic               rr_any;

    logic               sel_valid;
    logic [7:0]         sel_byte;
    logic               sel_last;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // Mux the owner's lane using the registered one-hot grant
    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_byte = sel_byte | req_byte[i*8 +: 8];
                sel_last = sel_last | req_last[i];
            end
        end
    end

    assign sel_valid = |(req_valid & gnt_oh);
    assign wdog_inc  = (wdog == CNT_MAX) ? wdog : wdog + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= 3'(NUM_REQ - 1);
            gnt_oh      <= '0;
            last_flag   <= 1'b0;
            wdog        <= '0;
            req_ready   <= '0;
            tx_dv       <= 1'b0;
            tx_byte     <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_dv       <= 1'b0;
            req_ready   <= '0;
            timeout_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rr_any) begin
                        grant_id <= rr_idx;
                        gnt_oh   <= rr_gnt;
                        busy     <= 1'b1;
                        wdog     <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sel_valid && !tx_active) begin
                        tx_dv     <= 1'b1;
                        tx_byte   <= sel_byte;
                        req_ready <= gnt_oh;
                        last_flag <= sel_last;
                        wdog      <= '0;
                        state     <= ST_WAIT_DONE;
                    end else if (wdog >= TMO) begin
                        timeout_err <= 1'b1;
                        ptr         <= grant_id;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    // tx_done is checked first so it beats a same-cycle expiry
                    if (tx_done) begin
                        if (last_flag) begin
                            ptr   <= grant_id;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            wdog  <= '0;
                            state <= ST_ISSUE;
                        end
                    end else if (wdog >= TMO) begin
                        timeout_err <= 1'b1;
                        ptr         <= grant_id;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a small uart_tx model.
// Two requesters; frame time of the model is fixed so byte spacing is exact.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 2;
    localparam int TMOC  = 120;
    localparam int FRAME = 10;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [15:0]     req_byte;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic            tx_active;
    logic            tx_done;
    logic [2:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    logic       v [NREQ];
    logic [7:0] b [NREQ];
    logic       l [NREQ];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_tmo = 0;
    int n_cross = 0;
    int done_cyc = 0;
    int tmo_cyc  = 0;
    int t0;
    int m_cnt;

    logic [7:0] lg_byte [$];
    logic [2:0] lg_gnt  [$];
    int         lg_cyc  [$];

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .TIMEOUT_CYC (TMOC),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_byte    (req_byte),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = v[i];
            req_byte[i*8 +: 8] = b[i];
            req_last[i]        = l[i];
        end
    end

    // uart_tx stand-in: active for FRAME cycles, then a one-cycle done
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            m_cnt     <= 0;
        end else begin
            tx_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                end
            end else if (tx_dv) begin
                tx_active <= 1'b1;
                m_cnt     <= FRAME;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_dv) begin
            lg_byte.push_back(tx_byte);
            lg_gnt.push_back(grant_id);
            lg_cyc.push_back(cyc);
        end
        if (tx_done) done_cyc = cyc;
        if (timeout_err) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
        if (|(req_ready & ~(2'b01 << grant_id))) n_cross++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int i);
        return {21'b0, lg_gnt[i], lg_byte[i]};
    endfunction

    task automatic clr_log();
        lg_byte.delete();
        lg_gnt.delete();
        lg_cyc.delete();
    endtask

    task automatic send_byte(input int id, input logic [7:0] bt,
                             input logic last);
        bit ok;
        ok = 1'b0;
        v[id] = 1'b1;
        b[id] = bt;
        l[id] = last;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        v[id] = 1'b0;
        l[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            b[i] = '0;
            l[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx_dv", 32'(tx_dv), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Contention after reset: req0 frame first, then req1
        @(posedge clk);
        #1;
        clr_log();
        t0 = cyc;
        fork
            begin
                send_byte(0, 8'hA1, 1'b0);
                send_byte(0, 8'hA2, 1'b1);
            end
            begin
                send_byte(1, 8'hB1, 1'b0);
                send_byte(1, 8'hB2, 1'b1);
            end
        join
        wait_idle();
        check("c1_len", 32'(lg_byte.size()), 32'd4);
        check("c1_e0", ent(0), 32'h0A1);
        check("c1_e1", ent(1), 32'h0A2);
        check("c1_e2", ent(2), 32'h1B1);
        check("c1_e3", ent(3), 32'h1B2);
        check("c1_latency", 32'(lg_cyc[0] - t0), 32'd2);
        check("c1_spacing", 32'(lg_cyc[1] - lg_cyc[0]), 32'd13);

        // Single frame from req0
        clr_log();
        send_byte(0, 8'hA5, 1'b0);
        send_byte(0, 8'h10, 1'b0);
        send_byte(0, 8'h04, 1'b1);
        check("s_busy_mid", 32'(busy), 32'd1);
        wait_idle();
        check("s_len", 32'(lg_byte.size()), 32'd3);
        check("s_e0", ent(0), 32'h0A5);
        check("s_e1", ent(1), 32'h010);
        check("s_e2", ent(2), 32'h004);
        check("s_spacing", 32'(lg_cyc[2] - lg_cyc[1]), 32'd13);
        check("s_grant", 32'(grant_id), 32'd0);
        check("s_busy", 32'(busy), 32'd0);

        // Second contention: req0 served last, so req1 wins now
        clr_log();
        fork
            send_byte(0, 8'hD1, 1'b1);
            send_byte(1, 8'hC1, 1'b1);
        join
        wait_idle();
        check("c2_e0", ent(0), 32'h1C1);
        check("c2_e1", ent(1), 32'h0D1);

        // req1 arrives mid-frame and must wait for req0's last byte
        clr_log();
        fork
            begin
                send_byte(0, 8'hE1, 1'b0);
                send_byte(0, 8'hE2, 1'b0);
                send_byte(0, 8'hE3, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                send_byte(1, 8'hF1, 1'b1);
            end
        join
        wait_idle();
        check("ni_len", 32'(lg_byte.size()), 32'd4);
        check("ni_e2", ent(2), 32'h0E3);
        check("ni_e3", ent(3), 32'h1F1);
        check("ni_cross", 32'(n_cross), 32'd0);

        // 100-cycle gap inside a frame keeps the grant, no timeout
        clr_log();
        fork
            begin
                send_byte(0, 8'h31, 1'b0);
                repeat (100) @(posedge clk);
                #1;
                send_byte(0, 8'h32, 1'b1);
            end
            begin
                @(posedge clk);
                #1;
                send_byte(1, 8'h41, 1'b1);
            end
        join
        wait_idle();
        check("gap_e0", ent(0), 32'h031);
        check("gap_e1", ent(1), 32'h032);
        check("gap_e2", ent(2), 32'h141);
        check("gap_tmo", 32'(n_tmo), 32'd0);

        // Stalled frame: watchdog aborts, req1 granted next
        clr_log();
        send_byte(0, 8'h51, 1'b0);
        send_byte(1, 8'h61, 1'b1);
        check("wd_delay", 32'(tmo_cyc - done_cyc), 32'(TMOC + 2));
        wait_idle();
        check("wd_count", 32'(n_tmo), 32'd1);
        check("wd_e0", ent(0), 32'h051);
        check("wd_e1", ent(1), 32'h161);
        check("wd_grant", 32'(grant_id), 32'd1);

        // Reset while waiting on tx_done
        send_byte(1, 8'h71, 1'b1);
        @(negedge clk);
        check("r_busy_pre", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("r_busy", 32'(busy), 32'd0);
        check("r_grant", 32'(grant_id), 32'd0);
        check("r_tx_byte", 32'(tx_byte), 32'd0);
        check("r_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clr_log();
        @(posedge clk);
        #1;
        send_byte(1, 8'h91, 1'b1);
        wait_idle();
        check("r_len", 32'(lg_byte.size()), 32'd1);
        check("r_e0", ent(0), 32'h191);
        check("r_grant_after", 32'(grant_id), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
